// File: rtl/display_scanout_if.sv
// display_scanout_if: frame buffer read port between scanout and buffer.
// master = scanout side, slave = buffer side.
interface display_scanout_if;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;

  modport master (
    output rd_en, rd_addr,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  rd_en, rd_addr,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/display_scanout.sv
// display_scanout: raster scan of the RGB frame buffer to display timing.
// Optional SCANOUT_TEST_PATTERN_EN adds pattern_sel for 8 colour bars.
module display_scanout #(
  parameter int unsigned H_ACTIVE = 100,
  parameter int unsigned H_FRONT  = 4,
  parameter int unsigned H_SYNC   = 8,
  parameter int unsigned H_BACK   = 4,
  parameter int unsigned V_ACTIVE = 100,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic pattern_sel,
`endif
  display_scanout_if.master fb,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic de,
  output logic hsync,
  output logic vsync,
  output logic frame_start,
  output logic busy
);
  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HA_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END  =
    HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END  =
    VW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [19:0]   addr;
  logic          run, last, active;
  logic          hs_c, vs_c, fs_c;
  logic          de1, hs1, vs1, fs1;
  logic [7:0]    r_n, g_n, b_n;

  assign run    = (state == RUN);
  assign last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign active = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_c   = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_c   = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign fs_c   = run && (h_cnt == '0) && (v_cnt == '0);
  assign busy   = run;

  assign fb.rd_addr = addr;
`ifdef SCANOUT_TEST_PATTERN_EN
  assign fb.rd_en = active & ~pattern_sel;
`else
  assign fb.rd_en = active;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // enable only matters in IDLE and on the final cycle of a frame
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (enable) state_n = RUN;
      RUN:  if (last && !enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      addr <= '0;
    end else if (active) begin
      if (h_cnt == HA_LAST && v_cnt == VA_LAST) addr <= '0;
      else addr <= addr + 20'd1;
    end
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [HW-1:0] h1;
  logic          pat1;
  logic [2:0]    bar;
  logic [7:0]    bar_pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      h1   <= '0;
      pat1 <= 1'b0;
    end else begin
      h1   <= h_cnt;
      pat1 <= pattern_sel;
    end
  end

  assign bar     = 3'((32'(h1) * 32'd8) / 32'(H_ACTIVE));
  assign bar_pix = {bar, 5'd0};
`endif

  always_comb begin
    r_n = fb.r_in;
    g_n = fb.g_in;
    b_n = fb.b_in;
`ifdef SCANOUT_TEST_PATTERN_EN
    if (pat1) begin
      r_n = bar_pix;
      g_n = bar_pix;
      b_n = bar_pix;
    end
`endif
  end

  // two-stage delay so sync/de line up with the registered buffer data
  always_ff @(posedge clk) begin
    if (reset) begin
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      fs1         <= 1'b0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
    end else begin
      de1         <= active;
      hs1         <= hs_c;
      vs1         <= vs_c;
      fs1         <= fs_c;
      de          <= de1;
      hsync       <= hs1;
      vsync       <= vs1;
      frame_start <= fs1;
      r_out       <= de1 ? r_n : '0;
      g_out       <= de1 ? g_n : '0;
      b_out       <= de1 ? b_n : '0;
    end
  end
endmodule

// File: tb/tb_display_scanout.sv
// tb_display_scanout: frame-position model plus directed checks
// for display_scanout with an address-encoded buffer.
module tb_display_scanout;
  localparam int HA = 100;
  localparam int HT = 116;
  localparam int VA = 100;
  localparam int VT = 106;
  localparam int FP = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] r_out, g_out, b_out;
  logic       de, hsync, vsync, frame_start, busy;
`ifdef SCANOUT_TEST_PATTERN_EN
  logic       pattern_sel = 1'b0;
`endif

  display_scanout_if fb();

  display_scanout dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
`ifdef SCANOUT_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .fb(fb),
    .r_out(r_out),
    .g_out(g_out),
    .b_out(b_out),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  bit     model_on = 1'b1;
  bit     measure = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] pr(logic [19:0] a);
    return a[7:0];
  endfunction
  function automatic logic [7:0] pg(logic [19:0] a);
    return a[15:8];
  endfunction
  function automatic logic [7:0] pb(logic [19:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // buffer: registered read, junk on the bus when not read
  always @(posedge clk) begin
    if (fb.rd_en === 1'b1) begin
      fb.r_in <= pr(fb.rd_addr);
      fb.g_in <= pg(fb.rd_addr);
      fb.b_in <= pb(fb.rd_addr);
    end else begin
      fb.r_in <= 8'hA5;
      fb.g_in <= 8'hA5;
      fb.b_in <= 8'hA5;
    end
  end

  typedef struct packed {
    logic        run;
    logic        rd;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [19:0] addr;
  } ideal_t;

  ideal_t cur = '0;
  ideal_t p1 = '0;
  ideal_t dexp = '0;
  longint origin = 0;
  bit     running = 1'b0;

  function automatic ideal_t ideal_at(longint t, bit rn, longint org);
    ideal_t x;
    int p, h, v;
    x = '0;
    if (rn) begin
      p = int'((t - org) % FP);
      h = p % HT;
      v = p / HT;
      x.run  = 1'b1;
      x.rd   = (h < HA) && (v < VA);
      x.addr = 20'(v * HA + h);
      x.hs   = (h >= HA + 4) && (h < HA + 12);
      x.vs   = (v >= VA + 2) && (v < VA + 4);
      x.fs   = (p == 0);
    end
    return x;
  endfunction

  always @(posedge clk) begin
    cyc++;
    dexp = p1;
    p1 = cur;
    if (reset) begin
      running = 1'b0;
      dexp = '0;
      p1 = '0;
    end else if (!running) begin
      if (enable) begin
        running = 1'b1;
        origin = cyc;
      end
    end else if ((cyc - 1 - origin) % FP == FP - 1 && !enable) begin
      running = 1'b0;
    end
    cur = ideal_at(cyc, running, origin);
  end

  always @(negedge clk) begin
    if (model_on && cyc > 0) begin
      chk("rd_en", fb.rd_en, cur.rd);
      if (cur.rd || !cur.run)
        chk("rd_addr", fb.rd_addr, cur.rd ? cur.addr : 20'd0);
      chk("busy", busy, cur.run);
      chk("de", de, dexp.rd);
      chk("hsync", hsync, dexp.hs);
      chk("vsync", vsync, dexp.vs);
      chk("frame_start", frame_start, dexp.fs);
      chk("r_out", r_out, dexp.rd ? pr(dexp.addr) : 8'd0);
      chk("g_out", g_out, dexp.rd ? pg(dexp.addr) : 8'd0);
      chk("b_out", b_out, dexp.rd ? pb(dexp.addr) : 8'd0);
    end
  end

  longint last_fs = -1;
  longint de_rise = -1;
  longint hs_rise = -1;
  int     de_run = 0;
  int     rd_count = 0;
  int     max_addr = 0;
  int     pat_rd = 0;
  bit     de_q = 1'b0;
  bit     hs_q = 1'b0;

  // literal timing measurements on the display side
  always @(negedge clk) begin
    if (measure) begin
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 12296);
        last_fs = cyc;
      end
      if (de) de_run++;
      if (de && !de_q) de_rise = cyc;
      if (!de && de_q) begin
        chk("de_per_line", de_run, 100);
        de_run = 0;
      end
      if (hsync && !hs_q) begin
        hs_rise = cyc;
        if (de_rise >= 0 && cyc - de_rise < HT)
          chk("hs_offset", 32'(cyc - de_rise), 104);
      end
      if (!hsync && hs_q && hs_rise >= 0)
        chk("hs_width", 32'(cyc - hs_rise), 8);
      if (fb.rd_en) begin
        rd_count++;
        if (int'(fb.rd_addr) > max_addr) max_addr = int'(fb.rd_addr);
      end
      de_q = de;
      hs_q = hsync;
    end
    if (!model_on && fb.rd_en === 1'b1) pat_rd++;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  longint c;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    step(3);
    reset = 1'b0;
    step(5);
    chk("idle_busy", busy, 0);
    chk("idle_rd_en", fb.rd_en, 0);
    chk("idle_de", de, 0);

    measure = 1'b1;
    enable = 1'b1;
    c = cyc;
    step(1);
    chk("start_rd_en", fb.rd_en, 1);
    chk("start_addr", fb.rd_addr, 0);
    step(2);
    chk("start_fs", frame_start, 1);
    chk("start_de", de, 1);
    chk("start_r", r_out, 8'h00);
    chk("start_b", b_out, 8'h5A);
    step(2 * FP + 50 * HT - 2);
    enable = 1'b0;
    step(FP - 50 * HT - 1);
    chk("last_cycle_busy", busy, 1);
    step(1);
    chk("drop_busy", busy, 0);
    chk("drop_rd_en", fb.rd_en, 0);
    step(50);
    chk("rd_count", rd_count, 30000);
    chk("max_addr", max_addr, 9999);
    measure = 1'b0;

    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(500);
    reset = 1'b1;
    step(3);
    chk("rst_de", de, 0);
    chk("rst_r", r_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", fb.rd_addr, 0);
    chk("rst_hsync", hsync, 0);
    reset = 1'b0;
    step(20);

`ifdef SCANOUT_TEST_PATTERN_EN
    model_on = 1'b0;
    pattern_sel = 1'b1;
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(2);
    chk("pat_fs", frame_start, 1);
    chk("pat_h0", r_out, 8'h00);
    step(99);
    chk("pat_h99", r_out, 8'hE0);
    chk("pat_h99_g", g_out, 8'hE0);
    step(300);
    chk("pat_no_rd", pat_rd, 0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    pattern_sel = 1'b0;
    step(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
